fetch_unit: RTL and testbench

Instruction-fetch stage of the RV32I core, directly upstream of main_decoder.
- Owns the PC and issues one request at a time to instruction memory.
- Registers the returned word and presents it, plus its opcode field, to decode with a valid/ready handshake.
- Applies the taken-branch redirect that execute reports for the instruction being consumed.

---
 rtl/rv32_pkg.sv | 17 +
 rtl/pc_next_logic.sv | 26 ++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcode constants, the NOP encoding and the fetch FSM state type.
package rv32_pkg;

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        S_REQ   = 1'b0,
        S_VALID = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection for fetch: sequential step or word-aligned branch target,
// with a flag for redirect targets that were not word aligned.
module pc_next_logic
    import rv32_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PC_STEP = 4
) (
    input  logic [XLEN-1:0] instr_pc,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] pc_next,
    output logic            misalign
);

    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] pc_aligned;

    // Sequential step wraps naturally at 2^XLEN.
    assign pc_seq     = instr_pc + XLEN'(PC_STEP);
    assign pc_aligned = {pc_target[XLEN-1:2], 2'b00};

    assign pc_next  = pc_src ? pc_aligned : pc_seq;
    assign misalign = pc_src && (pc_target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, registered instruction
// handed to decode over valid/ready, branch redirect applied on the handshake.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_REQ   | request pc from imem, wait for imem_rvalid
//   S_VALID | instruction registered and offered to decode, wait for ready
module fetch_unit
    import rv32_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic            misalign_err,
    output logic [31:0]     instr_count
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            misalign_q;
    logic [31:0]     count_q;

    logic            handshake;
    logic [XLEN-1:0] pc_next;
    logic            misalign;

    assign handshake = (state == S_VALID) && instr_ready;

    pc_next_logic #(
        .XLEN    (XLEN),
        .PC_STEP (PC_STEP)
    ) u_pc_next (
        .instr_pc  (instr_pc_q),
        .pc_src    (pc_src),
        .pc_target (pc_target),
        .pc_next   (pc_next),
        .misalign  (misalign)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            instr_q    <= XLEN'(NOP_INSTR);
            instr_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_rvalid) begin
                        instr_q    <= imem_rdata;
                        instr_pc_q <= pc;
                        state      <= S_VALID;
                    end
                end
                S_VALID: begin
                    // A stray imem_rvalid here is a protocol violation and is dropped.
                    if (handshake) begin
                        pc         <= pc_next;
                        misalign_q <= misalign_q | misalign;
                        count_q    <= count_q + 32'd1;
                        state      <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // Reset gating is the only non-registered term on the request.
    assign imem_req     = rst_n && (state == S_REQ);
    assign imem_addr    = pc;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign opcode       = instr_q[6:0];
    assign instr_valid  = (state == S_VALID);
    assign misalign_err = misalign_q;
    assign instr_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: an imem model with random wait
// states, a random consumer with random redirects, and a queue-based reference.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] pc_target = '0;
    logic        misalign_err;
    logic [31:0] instr_count;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    bit          run = 1'b0;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RESET_PC),
        .PC_STEP  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .opcode       (opcode),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc_src       (pc_src),
        .pc_target    (pc_target),
        .misalign_err (misalign_err),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    // Memory contents as a pure function of address, with a realistic opcode field.
    function automatic logic [31:0] memf(input logic [31:0] addr);
        logic [31:0] w;
        logic [6:0]  ops [4];
        ops[0] = 7'b0000011;
        ops[1] = 7'b0100011;
        ops[2] = 7'b0110011;
        ops[3] = 7'b1100011;
        w = (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
        return {w[31:7], ops[addr[3:2]]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory: random 0..3 wait cycles, stray responses when idle,
    // and a stale response held up throughout reset.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
                wcnt        = $urandom_range(0, 3);
            end else if (imem_req) begin
                if (wcnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = memf(imem_addr);
                    wcnt        = $urandom_range(0, 3);
                end else begin
                    wcnt--;
                    imem_rvalid = 1'b0;
                    imem_rdata  = $urandom;
                end
            end else begin
                imem_rvalid = ($urandom_range(0, 7) == 0);
                imem_rdata  = $urandom;
            end
        end
    end

    // Consumer: random ready and random redirects, also offered without ready.
    initial begin
        int r;
        forever begin
            @(posedge clk);
            #2;
            instr_ready = ($urandom_range(0, 1) == 1);
            pc_src      = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 15);
            if (r == 0)      pc_target = ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
            else if (r == 1) pc_target = 32'hFFFF_FFFC;
            else if (r == 2) pc_target = 32'hFFFF_FFF8;
            else             pc_target = $urandom_range(0, 4095) << 2;
        end
    end

    // Reference model and monitor: queue holds the PCs the fetch stage must
    // request and deliver, in order.
    logic [31:0] exp_q[$];
    logic [31:0] cur_pc;
    logic [31:0] cur_word;
    logic [31:0] m_count;
    logic [31:0] nxt;
    bit          m_mis;
    bit          have_cur;
    bit          exp_v;
    bit          exp_nv;
    int          idle_cyc;

    always @(negedge clk) begin
        if (run) begin
            idle_cyc++;
            if (!rst_n) begin
                chk("req_in_reset", {31'd0, imem_req}, 32'd0);
                exp_q.delete();
                exp_q.push_back(RESET_PC);
                m_count  = '0;
                m_mis    = 1'b0;
                have_cur = 1'b0;
                exp_v    = 1'b0;
                exp_nv   = 1'b0;
                idle_cyc = 0;
            end else begin
                if (exp_v)  chk("valid_latency", {31'd0, instr_valid}, 32'd1);
                if (exp_nv) chk("valid_drop", {31'd0, instr_valid}, 32'd0);
                exp_v  = 1'b0;
                exp_nv = 1'b0;
                if (instr_valid) begin
                    chk("req_while_valid", {31'd0, imem_req}, 32'd0);
                    if (!have_cur) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL scoreboard_empty: instr_pc %h with nothing expected", instr_pc);
                            cur_pc = instr_pc;
                        end else begin
                            cur_pc = exp_q.pop_front();
                        end
                        have_cur = 1'b1;
                    end
                    cur_word = memf(cur_pc);
                    chk("instr", instr, cur_word);
                    chk("instr_pc", instr_pc, cur_pc);
                    chk("opcode", {25'd0, opcode}, {25'd0, cur_word[6:0]});
                    if (instr_ready) begin
                        chk("instr_count", instr_count, m_count);
                        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
                        if (pc_src) begin
                            nxt = pc_target & 32'hFFFF_FFFC;
                            if (pc_target[1:0] != 2'b00) m_mis = 1'b1;
                        end else begin
                            nxt = cur_pc + 32'd4;
                        end
                        m_count  = m_count + 32'd1;
                        exp_q.push_back(nxt);
                        have_cur = 1'b0;
                        exp_nv   = 1'b1;
                        idle_cyc = 0;
                    end
                end else begin
                    chk("imem_req", {31'd0, imem_req}, 32'd1);
                    if (exp_q.size() > 0) chk("imem_addr", imem_addr, exp_q[0]);
                    if (imem_rvalid) exp_v = 1'b1;
                end
            end
            if (idle_cyc > 100) begin
                n_cmp++;
                n_fail++;
                $display("FAIL timeout: no handshake for %0d cycles", idle_cyc);
                idle_cyc = 0;
            end
        end
    end

    initial begin
        bit hit;
        rst_n = 1'b0;
        run   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (1500) @(posedge clk);
        // Reset while a request is outstanding; the memory holds a stale response up.
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (imem_req) hit = 1'b1;
        end
        if (!hit) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_req: imem_req never seen, got 0 expected 1");
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (1500) @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
